game_round_ctrl: RTL and testbench

Round sequencer for the memorization game. It requests a target number from the random source and shows it for a fixed number of display ticks, then blanks it. It then collects up to four decimal digits from the keypad, compares the entry against the target, and keeps score and lives. It sits between the keypad/tick logic, the random-number source, the comparator and the 7-segment display driver.

---
 rtl/game_round_ctrl_if.sv | 42 ++++
 rtl/game_round_ctrl.sv | 170 +++++++++++++++++
 tb/tb_game_round_ctrl.sv | 334 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/game_round_ctrl_if.sv
// Signal bundle between the round sequencer and its neighbours: keypad/tick
// logic, random-number source, comparator and 7-segment display driver.
// The sequencer uses the slave view; whatever drives the keypad, timebase
// and random source uses the master view.
interface game_round_ctrl_if;
  // Control and timebase
  logic        start;
  logic        tick;

  // Random-number source handshake
  logic        rand_req;
  logic        rand_valid;
  logic [13:0] rand_in;

  // Keypad
  logic        key_valid;
  logic [3:0]  key_digit;
  logic        enter;

  // Display, result and game status
  logic [13:0] target;
  logic        show_target;
  logic [13:0] user_val;
  logic [2:0]  digit_cnt;
  logic        result_valid;
  logic        correct;
  logic [7:0]  score;
  logic [2:0]  lives;
  logic        game_over;

  modport master (
    output start, tick, rand_valid, rand_in, key_valid, key_digit, enter,
    input  rand_req, target, show_target, user_val, digit_cnt,
           result_valid, correct, score, lives, game_over
  );

  modport slave (
    input  start, tick, rand_valid, rand_in, key_valid, key_digit, enter,
    output rand_req, target, show_target, user_val, digit_cnt,
           result_valid, correct, score, lives, game_over
  );
endinterface

// File: rtl/game_round_ctrl.sv
// Round sequencer for the memorization game: fetch a target, show it for a
// fixed number of ticks, collect a keypad entry, compare it, and keep score
// and lives. Every output comes straight from a flop; the combinational
// block computes the next value of each register.
module game_round_ctrl #(
  parameter int SHOW_TICKS  = 3,  // ticks the target stays visible (1..15)
  parameter int MAX_DIGITS  = 4,  // digits accepted per entry (1..4)
  parameter int START_LIVES = 3   // lives loaded at game start (1..7)
) (
  input  logic             clk,
  input  logic             rst,
  game_round_ctrl_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    GEN   = 3'd1,
    SHOW  = 3'd2,
    ENTRY = 3'd3,
    CHECK = 3'd4,
    OVER  = 3'd5
  } state_t;

  localparam logic [3:0]  LAST_TICK  = 4'(SHOW_TICKS - 1);
  localparam logic [2:0]  DIGIT_MAX  = 3'(MAX_DIGITS);
  localparam logic [2:0]  LIVES_INIT = 3'(START_LIVES);
  localparam logic [13:0] TARGET_MAX = 14'd9999;
  localparam logic [13:0] WRAP       = 14'd10000;

  state_t      state_q, state_d;
  logic [3:0]  tick_cnt_q, tick_cnt_d;
  logic        rand_req_q, rand_req_d;
  logic [13:0] target_q, target_d;
  logic        show_q, show_d;
  logic [13:0] user_val_q, user_val_d;
  logic [2:0]  digit_cnt_q, digit_cnt_d;
  logic        result_valid_q, result_valid_d;
  logic        correct_q, correct_d;
  logic [7:0]  score_q, score_d;
  logic [2:0]  lives_q, lives_d;
  logic        over_q, over_d;

  logic        key_ok;
  logic        match;

  // A key counts only in ENTRY-relevant form: a decimal digit with room left.
  assign key_ok = bus.key_valid && (bus.key_digit <= 4'd9) && (digit_cnt_q < DIGIT_MAX);
  assign match  = (user_val_q == target_q);

  // State register with synchronous reset.
  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state and next-register logic for the whole round.
  // NOTE: every signal written here gets a default first, so no path leaves
  // a value unassigned and no latch is inferred.
  always_comb begin
    state_d        = state_q;
    tick_cnt_d     = tick_cnt_q;
    target_d       = target_q;
    user_val_d     = user_val_q;
    digit_cnt_d    = digit_cnt_q;
    correct_d      = correct_q;
    score_d        = score_q;
    lives_d        = lives_q;
    result_valid_d = 1'b0;

    case (state_q)
      IDLE, OVER: begin
        if (bus.start) begin
          state_d   = GEN;
          score_d   = 8'd0;
          lives_d   = LIVES_INIT;
          correct_d = 1'b0;
        end
      end

      GEN: begin
        if (bus.rand_valid) begin
          // Fold the 14-bit raw value into 0..9999 with one subtraction.
          target_d    = (bus.rand_in <= TARGET_MAX) ? bus.rand_in : bus.rand_in - WRAP;
          tick_cnt_d  = 4'd0;
          user_val_d  = 14'd0;
          digit_cnt_d = 3'd0;
          state_d     = SHOW;
        end
      end

      SHOW: begin
        if (bus.tick) begin
          if (tick_cnt_q == LAST_TICK) state_d = ENTRY;
          else                         tick_cnt_d = tick_cnt_q + 4'd1;
        end
      end

      ENTRY: begin
        if (key_ok) begin
          user_val_d  = user_val_q * 14'd10 + {10'd0, bus.key_digit};
          digit_cnt_d = digit_cnt_q + 3'd1;
        end
        // Uses the post-key count so a digit arriving with enter is included.
        if (bus.enter && (digit_cnt_d != 3'd0)) state_d = CHECK;
      end

      CHECK: begin
        result_valid_d = 1'b1;
        correct_d      = match;
        if (match) begin
          if (score_q != 8'hFF) score_d = score_q + 8'd1;
          state_d = GEN;
        end else begin
          lives_d = lives_q - 3'd1;
          state_d = (lives_d == 3'd0) ? OVER : GEN;
        end
      end

      default: state_d = IDLE;
    endcase

    // Request a new target only on the first cycle spent in GEN.
    rand_req_d = (state_d == GEN) && (state_q != GEN);
    show_d     = (state_d == SHOW);
    over_d     = (state_d == OVER);
  end

  // Datapath and output registers; all outputs are driven from here.
  always_ff @(posedge clk) begin
    if (rst) begin
      tick_cnt_q     <= 4'd0;
      rand_req_q     <= 1'b0;
      target_q       <= 14'd0;
      show_q         <= 1'b0;
      user_val_q     <= 14'd0;
      digit_cnt_q    <= 3'd0;
      result_valid_q <= 1'b0;
      correct_q      <= 1'b0;
      score_q        <= 8'd0;
      lives_q        <= 3'd0;
      over_q         <= 1'b0;
    end else begin
      tick_cnt_q     <= tick_cnt_d;
      rand_req_q     <= rand_req_d;
      target_q       <= target_d;
      show_q         <= show_d;
      user_val_q     <= user_val_d;
      digit_cnt_q    <= digit_cnt_d;
      result_valid_q <= result_valid_d;
      correct_q      <= correct_d;
      score_q        <= score_d;
      lives_q        <= lives_d;
      over_q         <= over_d;
    end
  end

  assign bus.rand_req     = rand_req_q;
  assign bus.target       = target_q;
  assign bus.show_target  = show_q;
  assign bus.user_val     = user_val_q;
  assign bus.digit_cnt    = digit_cnt_q;
  assign bus.result_valid = result_valid_q;
  assign bus.correct      = correct_q;
  assign bus.score        = score_q;
  assign bus.lives        = lives_q;
  assign bus.game_over    = over_q;

endmodule

// File: tb/tb_game_round_ctrl.sv
// Directed bench for game_round_ctrl with SHOW_TICKS=3, MAX_DIGITS=4,
// START_LIVES=3. Inputs change 1 ns after a rising edge and outputs are
// read at the same point, so each read reflects the edge just taken.
module tb_game_round_ctrl;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  game_round_ctrl_if bus();

  game_round_ctrl #(
    .SHOW_TICKS (3),
    .MAX_DIGITS (4),
    .START_LIVES(3)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int checks   = 0;
  int failures = 0;

  // Advance one clock edge and settle just after it.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    bus.start      = 1'b0;
    bus.tick       = 1'b0;
    bus.rand_valid = 1'b0;
    bus.rand_in    = 14'd0;
    bus.key_valid  = 1'b0;
    bus.key_digit  = 4'd0;
    bus.enter      = 1'b0;
  endtask

  task automatic pulse_start();
    bus.start = 1'b1; cyc(); bus.start = 1'b0;
  endtask

  task automatic pulse_tick();
    bus.tick = 1'b1; cyc(); bus.tick = 1'b0;
  endtask

  task automatic pulse_enter();
    bus.enter = 1'b1; cyc(); bus.enter = 1'b0;
  endtask

  task automatic press(input logic [3:0] d);
    bus.key_valid = 1'b1; bus.key_digit = d; cyc();
    bus.key_valid = 1'b0; bus.key_digit = 4'd0;
  endtask

  task automatic give_rand(input logic [13:0] v);
    bus.rand_valid = 1'b1; bus.rand_in = v; cyc();
    bus.rand_valid = 1'b0; bus.rand_in = 14'd0;
  endtask

  // From GEN: target 0, entry "1", so the round is always lost.
  // Returns just after the edge where the result becomes visible.
  task automatic wrong_round();
    give_rand(14'd0);
    repeat (3) pulse_tick();
    press(4'd1);
    pulse_enter();
    cyc();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    cyc(); cyc();
    rst = 1'b0;
    checks++;
    if ({bus.rand_req, bus.target, bus.show_target, bus.user_val, bus.digit_cnt,
         bus.result_valid, bus.correct, bus.score, bus.lives, bus.game_over} !== 47'd0) begin
      failures++;
      $display("FAIL reset_outputs got=%h exp=0", {bus.rand_req, bus.target, bus.show_target,
               bus.user_val, bus.digit_cnt, bus.result_valid, bus.correct, bus.score,
               bus.lives, bus.game_over});
    end
    cyc(); cyc();
    checks++;
    if (bus.rand_req !== 1'b0) begin
      failures++; $display("FAIL reset_no_req got=%b exp=0", bus.rand_req);
    end
  endtask

  task automatic test_correct_round();
    pulse_start();
    checks++;
    if ({bus.rand_req, bus.score, bus.lives} !== {1'b1, 8'd0, 3'd3}) begin
      failures++;
      $display("FAIL start_init got req=%b score=%0d lives=%0d exp req=1 score=0 lives=3",
               bus.rand_req, bus.score, bus.lives);
    end
    cyc();
    checks++;
    if (bus.rand_req !== 1'b0) begin
      failures++; $display("FAIL req_single_pulse got=%b exp=0", bus.rand_req);
    end
    give_rand(14'd1234);
    checks++;
    if ({bus.show_target, bus.target} !== {1'b1, 14'd1234}) begin
      failures++;
      $display("FAIL show_1234 got show=%b target=%0d exp show=1 target=1234",
               bus.show_target, bus.target);
    end
    pulse_tick(); pulse_tick();
    checks++;
    if (bus.show_target !== 1'b1) begin
      failures++; $display("FAIL show_after_2_ticks got=%b exp=1", bus.show_target);
    end
    pulse_tick();
    checks++;
    if (bus.show_target !== 1'b0) begin
      failures++; $display("FAIL show_after_3_ticks got=%b exp=0", bus.show_target);
    end
    press(4'd1); press(4'd2); press(4'd3); press(4'd4);
    checks++;
    if ({bus.user_val, bus.digit_cnt} !== {14'd1234, 3'd4}) begin
      failures++;
      $display("FAIL entry_1234 got val=%0d cnt=%0d exp val=1234 cnt=4", bus.user_val, bus.digit_cnt);
    end
    pulse_enter();
    checks++;
    if (bus.result_valid !== 1'b0) begin
      failures++; $display("FAIL rv_in_check got=%b exp=0", bus.result_valid);
    end
    cyc();
    checks++;
    if ({bus.result_valid, bus.correct, bus.score, bus.rand_req} !== {1'b1, 1'b1, 8'd1, 1'b1}) begin
      failures++;
      $display("FAIL win_result got rv=%b ok=%b score=%0d req=%b exp rv=1 ok=1 score=1 req=1",
               bus.result_valid, bus.correct, bus.score, bus.rand_req);
    end
    cyc();
    checks++;
    if ({bus.result_valid, bus.correct, bus.rand_req} !== {1'b0, 1'b1, 1'b0}) begin
      failures++;
      $display("FAIL win_after got rv=%b ok=%b req=%b exp rv=0 ok=1 req=0",
               bus.result_valid, bus.correct, bus.rand_req);
    end
  endtask

  task automatic test_wrong_round();
    // A tick in the cycle that enters SHOW must not count.
    bus.tick = 1'b1;
    give_rand(14'd12345);
    bus.tick = 1'b0;
    checks++;
    if (bus.target !== 14'd2345) begin
      failures++; $display("FAIL target_wrap got=%0d exp=2345", bus.target);
    end
    pulse_tick(); pulse_tick();
    checks++;
    if (bus.show_target !== 1'b1) begin
      failures++; $display("FAIL coincident_tick_counted got show=%b exp=1", bus.show_target);
    end
    pulse_tick();
    press(4'd9); press(4'd9);
    pulse_enter();
    cyc();
    checks++;
    if ({bus.correct, bus.lives, bus.score, bus.rand_req, bus.game_over} !==
        {1'b0, 3'd2, 8'd1, 1'b1, 1'b0}) begin
      failures++;
      $display("FAIL lose_result got ok=%b lives=%0d score=%0d req=%b over=%b exp ok=0 lives=2 score=1 req=1 over=0",
               bus.correct, bus.lives, bus.score, bus.rand_req, bus.game_over);
    end
  endtask

  task automatic test_entry_limits();
    give_rand(14'd0);
    repeat (3) pulse_tick();
    pulse_enter();
    cyc();
    checks++;
    if ({bus.result_valid, bus.digit_cnt, bus.lives} !== {1'b0, 3'd0, 3'd2}) begin
      failures++;
      $display("FAIL empty_enter got rv=%b cnt=%0d lives=%0d exp rv=0 cnt=0 lives=2",
               bus.result_valid, bus.digit_cnt, bus.lives);
    end
    press(4'd11);
    checks++;
    if ({bus.user_val, bus.digit_cnt} !== {14'd0, 3'd0}) begin
      failures++;
      $display("FAIL non_digit got val=%0d cnt=%0d exp val=0 cnt=0", bus.user_val, bus.digit_cnt);
    end
    press(4'd5); press(4'd6); press(4'd7); press(4'd8); press(4'd9);
    checks++;
    if ({bus.user_val, bus.digit_cnt} !== {14'd5678, 3'd4}) begin
      failures++;
      $display("FAIL fifth_key got val=%0d cnt=%0d exp val=5678 cnt=4", bus.user_val, bus.digit_cnt);
    end
    pulse_enter();
    cyc();
    checks++;
    if ({bus.result_valid, bus.correct, bus.lives} !== {1'b1, 1'b0, 3'd1}) begin
      failures++;
      $display("FAIL limits_result got rv=%b ok=%b lives=%0d exp rv=1 ok=0 lives=1",
               bus.result_valid, bus.correct, bus.lives);
    end
  endtask

  task automatic test_show_ignore_same_cycle();
    give_rand(14'd127);
    press(4'd3);
    checks++;
    if ({bus.user_val, bus.digit_cnt} !== {14'd0, 3'd0}) begin
      failures++;
      $display("FAIL key_in_show got val=%0d cnt=%0d exp val=0 cnt=0", bus.user_val, bus.digit_cnt);
    end
    repeat (3) pulse_tick();
    press(4'd1); press(4'd2);
    bus.key_valid = 1'b1; bus.key_digit = 4'd7; bus.enter = 1'b1;
    cyc();
    bus.key_valid = 1'b0; bus.key_digit = 4'd0; bus.enter = 1'b0;
    checks++;
    if ({bus.user_val, bus.digit_cnt} !== {14'd127, 3'd3}) begin
      failures++;
      $display("FAIL key_with_enter got val=%0d cnt=%0d exp val=127 cnt=3", bus.user_val, bus.digit_cnt);
    end
    cyc();
    checks++;
    if ({bus.result_valid, bus.correct, bus.score, bus.lives} !== {1'b1, 1'b1, 8'd2, 3'd1}) begin
      failures++;
      $display("FAIL same_cycle_result got rv=%b ok=%b score=%0d lives=%0d exp rv=1 ok=1 score=2 lives=1",
               bus.result_valid, bus.correct, bus.score, bus.lives);
    end
  endtask

  task automatic test_game_over();
    wrong_round();
    checks++;
    if ({bus.game_over, bus.lives, bus.score, bus.rand_req} !== {1'b1, 3'd0, 8'd2, 1'b0}) begin
      failures++;
      $display("FAIL over_entry got over=%b lives=%0d score=%0d req=%b exp over=1 lives=0 score=2 req=0",
               bus.game_over, bus.lives, bus.score, bus.rand_req);
    end
    pulse_tick(); press(4'd5); pulse_enter(); cyc();
    checks++;
    if ({bus.game_over, bus.user_val, bus.digit_cnt, bus.result_valid, bus.score} !==
        {1'b1, 14'd1, 3'd1, 1'b0, 8'd2}) begin
      failures++;
      $display("FAIL over_hold got over=%b val=%0d cnt=%0d rv=%b score=%0d exp over=1 val=1 cnt=1 rv=0 score=2",
               bus.game_over, bus.user_val, bus.digit_cnt, bus.result_valid, bus.score);
    end
    pulse_start();
    checks++;
    if ({bus.rand_req, bus.score, bus.lives, bus.game_over} !== {1'b1, 8'd0, 3'd3, 1'b0}) begin
      failures++;
      $display("FAIL restart got req=%b score=%0d lives=%0d over=%b exp req=1 score=0 lives=3 over=0",
               bus.rand_req, bus.score, bus.lives, bus.game_over);
    end
    wrong_round();
    wrong_round();
    checks++;
    if ({bus.lives, bus.game_over} !== {3'd1, 1'b0}) begin
      failures++;
      $display("FAIL two_losses got lives=%0d over=%b exp lives=1 over=0", bus.lives, bus.game_over);
    end
    wrong_round();
    checks++;
    if ({bus.lives, bus.game_over} !== {3'd0, 1'b1}) begin
      failures++;
      $display("FAIL three_losses got lives=%0d over=%b exp lives=0 over=1", bus.lives, bus.game_over);
    end
    // Start is ignored outside IDLE/OVER, so this also tests restart from OVER.
    pulse_start();
    checks++;
    if ({bus.rand_req, bus.lives, bus.game_over} !== {1'b1, 3'd3, 1'b0}) begin
      failures++;
      $display("FAIL restart2 got req=%b lives=%0d over=%b exp req=1 lives=3 over=0",
               bus.rand_req, bus.lives, bus.game_over);
    end
  endtask

  task automatic test_reset_mid();
    give_rand(14'd55);
    rst = 1'b1; cyc(); rst = 1'b0;
    checks++;
    if ({bus.show_target, bus.target, bus.lives, bus.rand_req} !== {1'b0, 14'd0, 3'd0, 1'b0}) begin
      failures++;
      $display("FAIL rst_in_show got show=%b target=%0d lives=%0d req=%b exp show=0 target=0 lives=0 req=0",
               bus.show_target, bus.target, bus.lives, bus.rand_req);
    end
    // In IDLE, a stray rand_valid must not advance anything.
    give_rand(14'd9); cyc();
    checks++;
    if ({bus.rand_req, bus.show_target} !== {1'b0, 1'b0}) begin
      failures++;
      $display("FAIL idle_after_rst got req=%b show=%b exp req=0 show=0", bus.rand_req, bus.show_target);
    end
    pulse_start();
    give_rand(14'd5);
    repeat (3) pulse_tick();
    press(4'd5);
    pulse_enter();
    rst = 1'b1; cyc(); rst = 1'b0;
    checks++;
    if ({bus.result_valid, bus.correct, bus.score, bus.lives, bus.user_val, bus.digit_cnt} !==
        {1'b0, 1'b0, 8'd0, 3'd0, 14'd0, 3'd0}) begin
      failures++;
      $display("FAIL rst_in_check got rv=%b ok=%b score=%0d lives=%0d val=%0d cnt=%0d exp all 0",
               bus.result_valid, bus.correct, bus.score, bus.lives, bus.user_val, bus.digit_cnt);
    end
    cyc(); cyc();
    checks++;
    if ({bus.rand_req, bus.game_over, bus.result_valid} !== 3'b000) begin
      failures++;
      $display("FAIL idle_after_check_rst got req=%b over=%b rv=%b exp 0 0 0",
               bus.rand_req, bus.game_over, bus.result_valid);
    end
  endtask

  initial begin
    clear_inputs();
    rst = 1'b1;
    test_reset();
    test_correct_round();
    test_wrong_round();
    test_entry_limits();
    test_show_ignore_same_cycle();
    test_game_over();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
